// File: rtl/max_voltage_tracker.sv
// Sliding-window average of photodiode samples with hysteretic running-max tracking.
// NEW_MAX pulses on each new maximum; MAX_VALID presents the final maximum after a sweep drains.
module max_voltage_tracker #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 4
) (
    input  logic              CLK,
    input  logic              CNT_RST,
    input  logic              SWEEP_START,
    input  logic              SWEEP_END,
    input  logic              SAMPLE_VALID,
    input  logic [DATA_W-1:0] SAMPLE,
    output logic              NEW_MAX,
    output logic [DATA_W-1:0] MAX_VAL,
    output logic              MAX_VALID,
    output logic [2:0]        STATE
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        TRACK = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic [DEPTH-1:0][DATA_W-1:0]   win_q, win_d;
    logic [SUM_W-1:0]               sum_q, sum_d;
    logic [CNT_W-1:0]               fill_q, fill_d;
    logic                           cmp_vld_q, cmp_vld_d;
    logic                           cmp_load_q, cmp_load_d;
    logic [DATA_W-1:0]              max_q, max_d;
    logic                           new_max_q, new_max_d;
    logic                           max_valid_q, max_valid_d;
    logic                           drain_q, drain_d;

    logic                           accept, fill_last;
    logic [DATA_W-1:0]              avg;
    logic [DATA_W:0]                thresh;

    // State register plus all datapath flops
    always_ff @(posedge CLK or posedge CNT_RST) begin
        if (CNT_RST) begin
            state_q     <= IDLE;
            win_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_load_q  <= 1'b0;
            max_q       <= '0;
            new_max_q   <= 1'b0;
            max_valid_q <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_load_q  <= cmp_load_d;
            max_q       <= max_d;
            new_max_q   <= new_max_d;
            max_valid_q <= max_valid_d;
            drain_q     <= drain_d;
        end
    end

    // Next-state logic; SWEEP_START outranks everything
    always_comb begin
        state_d = state_q;
        if (SWEEP_START) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (SWEEP_END)                state_d = IDLE;
                    else if (accept && fill_last) state_d = TRACK;
                end
                TRACK:   if (SWEEP_END) state_d = DRAIN;
                DRAIN:   if (drain_q)   state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM-derived controls
    always_comb begin
        accept    = SAMPLE_VALID && !SWEEP_START && !SWEEP_END &&
                    (state_q == FILL || state_q == TRACK);
        fill_last = (state_q == FILL) && (fill_q == CNT_W'(DEPTH - 1));
        drain_d   = (state_q == DRAIN) && (state_d == DRAIN);
    end

    assign avg    = sum_q[SUM_W-1:AVG_LOG2];
    assign thresh = {1'b0, max_q} + (DATA_W+1)'(HYST);

    // Stage 1 updates the window; stage 2 compares the average it left behind
    always_comb begin
        win_d       = win_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        cmp_vld_d   = 1'b0;
        cmp_load_d  = 1'b0;
        max_d       = max_q;
        new_max_d   = 1'b0;
        max_valid_d = 1'b0;
        if (SWEEP_START) begin
            win_d  = '0;
            sum_d  = '0;
            fill_d = '0;
            max_d  = '0;
        end else begin
            if (cmp_vld_q && (cmp_load_q || ({1'b0, avg} > thresh))) begin
                max_d     = avg;
                new_max_d = 1'b1;
            end
            if (accept) begin
                win_d      = {win_q[DEPTH-2:0], SAMPLE};
                sum_d      = sum_q + SUM_W'(SAMPLE) - SUM_W'(win_q[DEPTH-1]);
                cmp_vld_d  = (state_q == TRACK) || fill_last;
                cmp_load_d = fill_last;
                if (state_q == FILL) fill_d = fill_q + CNT_W'(1);
            end
            max_valid_d = (state_d == DONE);
        end
    end

    assign NEW_MAX   = new_max_q;
    assign MAX_VAL   = max_q;
    assign MAX_VALID = max_valid_q;
    assign STATE     = state_q;
endmodule

// File: tb/tb_max_voltage_tracker.sv
// Directed bench for max_voltage_tracker: queue-based window model compared every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_max_voltage_tracker;
    localparam int DATA_W = 12;
    localparam int HYST   = 4;

    logic              clk = 1'b0;
    logic              cnt_rst = 1'b0;
    logic              sweep_start = 1'b0, sweep_end = 1'b0, sample_valid = 1'b0;
    logic [DATA_W-1:0] sample = '0;
    logic              new_max, max_valid;
    logic [DATA_W-1:0] max_val;
    logic [2:0]        state;

    int checks = 0, failures = 0, pulses = 0;

    max_voltage_tracker #(.DATA_W(DATA_W), .AVG_LOG2(2), .HYST(HYST)) dut (
        .CLK(clk), .CNT_RST(cnt_rst), .SWEEP_START(sweep_start), .SWEEP_END(sweep_end),
        .SAMPLE_VALID(sample_valid), .SAMPLE(sample), .NEW_MAX(new_max),
        .MAX_VAL(max_val), .MAX_VALID(max_valid), .STATE(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Behavioural model: window = last four accepted samples (zeros before), average
    // computed when a sample is accepted, judged against the held max one edge later.
    int ms = 0, mmax = 0, mnew = 0, mvalid = 0, mdrain = 0;
    int mpend = 0, mload = 0, mavg = 0, tot;
    int mq[$];
    bit acc;

    always @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            ms = 0; mq.delete(); mpend = 0; mload = 0; mavg = 0;
            mmax = 0; mnew = 0; mvalid = 0; mdrain = 0;
        end else begin
            acc  = sample_valid && !sweep_start && !sweep_end && (ms == 1 || ms == 2);
            mnew = 0;
            if (mpend != 0 && (mload != 0 || mavg > mmax + HYST)) begin
                mmax = mavg;
                mnew = 1;
            end
            mpend = 0; mload = 0;
            if (acc) begin
                mq.push_back(int'(sample));
                if (mq.size() > 4) void'(mq.pop_front());
                tot = 0;
                foreach (mq[i]) tot += mq[i];
                mavg = tot / 4;
                if (ms == 2) mpend = 1;
                else if (mq.size() == 4) begin mpend = 1; mload = 1; end
            end
            if (sweep_start) begin
                ms = 1; mq.delete(); mmax = 0; mnew = 0; mpend = 0; mload = 0;
            end else begin
                case (ms)
                    1: if (sweep_end) ms = 0; else if (mload != 0) ms = 2;
                    2: if (sweep_end) begin ms = 3; mdrain = 0; end
                    3: begin mdrain++; if (mdrain == 2) ms = 4; end
                    default: ;
                endcase
            end
            mvalid = (ms == 4) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (!cnt_rst) begin
            check("model_new_max", int'(new_max), mnew);
            check("model_max_val", int'(max_val), mmax);
            check("model_max_valid", int'(max_valid), mvalid);
            check("model_state", int'(state), ms);
            if (new_max) pulses++;
        end
    end

    task automatic step(input logic st, input logic en, input logic v, input int s);
        sweep_start  = st;
        sweep_end    = en;
        sample_valid = v;
        sample       = DATA_W'(s);
        @(negedge clk);
        #1;
    endtask

    task automatic feed(input int s, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, s);
    endtask

    int p0;

    initial begin
        cnt_rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        cnt_rst = 1'b0;
        check("reset_state", int'(state), 0);
        check("reset_max_val", int'(max_val), 0);

        // 1: reset mid-traffic, then a clean fill
        step(1'b1, 1'b0, 1'b0, 0);
        feed(50, 3);
        cnt_rst = 1'b1;
        #1;
        check("midrst_new_max", int'(new_max), 0);
        check("midrst_max_val", int'(max_val), 0);
        check("midrst_max_valid", int'(max_valid), 0);
        check("midrst_state", int'(state), 0);
        @(negedge clk);
        #1;
        cnt_rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 0);
        feed(100, 4);
        check("fill_no_early_pulse", int'(new_max), 0);
        step(1'b0, 1'b0, 1'b0, 0);
        check("fill_pulse", int'(new_max), 1);
        check("fill_max_val", int'(max_val), 100);
        check("fill_state", int'(state), 2);

        // 2: hysteresis
        p0 = pulses;
        feed(102, 4);
        feed(120, 4);
        step(1'b0, 1'b0, 1'b0, 0);
        check("hyst_pulses", pulses - p0, 3);
        check("hyst_max_val", int'(max_val), 120);

        // 3: noise rejection
        p0 = pulses;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, int'($urandom_range(123, 117)));
        step(1'b0, 1'b0, 1'b0, 0);
        check("noise_pulses", pulses - p0, 0);
        check("noise_max_val", int'(max_val), 120);

        // 4: sweep end with in-flight samples and a coincident dropped sample
        p0 = pulses;
        feed(200, 4);
        step(1'b0, 1'b1, 1'b1, 4000);
        check("drain_state0", int'(state), 3);
        check("drain_valid0", int'(max_valid), 0);
        step(1'b0, 1'b0, 1'b0, 0);
        check("drain_state1", int'(state), 3);
        check("drain_valid1", int'(max_valid), 0);
        step(1'b0, 1'b0, 1'b0, 0);
        check("done_state", int'(state), 4);
        check("done_valid", int'(max_valid), 1);
        check("done_max_val", int'(max_val), 200);
        check("drain_pulses", pulses - p0, 4);
        step(1'b0, 1'b0, 1'b1, 4000);
        check("done_hold", int'(max_val), 200);

        // 5: restart squashes in-flight compare; early end aborts
        step(1'b1, 1'b0, 1'b0, 0);
        feed(100, 4);
        feed(500, 1);
        step(1'b1, 1'b0, 1'b1, 700);
        check("restart_new_max", int'(new_max), 0);
        check("restart_max_val", int'(max_val), 0);
        check("restart_valid", int'(max_valid), 0);
        check("restart_state", int'(state), 1);
        step(1'b0, 1'b0, 1'b0, 0);
        check("restart_no_stale", int'(new_max), 0);
        feed(300, 2);
        step(1'b0, 1'b1, 1'b0, 0);
        check("early_end_state", int'(state), 0);
        check("early_end_valid", int'(max_valid), 0);
        check("early_end_max", int'(max_val), 0);

        // 6: full scale
        step(1'b1, 1'b0, 1'b0, 0);
        feed(4095, 4);
        step(1'b0, 1'b0, 1'b0, 0);
        check("fs_pulse", int'(new_max), 1);
        check("fs_max_val", int'(max_val), 4095);
        p0 = pulses;
        feed(4095, 1);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        check("fs_no_pulse", pulses - p0, 0);
        check("fs_hold", int'(max_val), 4095);
        step(1'b1, 1'b0, 1'b0, 0);
        check("fs_restart_clear", int'(max_val), 0);

        repeat (3) step(1'b0, 1'b0, 1'b0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
